seq_run_ctrl: RTL and testbench
===============================

Name: seq_run_ctrl

Overview:
- Command-driven controller and datapath for the three-term recurrence generator used in the sequence blocks.
- On a start command it loads three seed terms and emits exactly COUNT terms over a valid/ready stream, then reports completion.
- Adds sequencing the free-running generator lacks: programmable seeds and length, output backpressure, abort, and wrap detection.
- Sits between a command source (CPU-side register block or testbench driver) and a downstream stream consumer.

Parameters:
- W, 32, term width in bits; all arithmetic is mod 2^W.
- CW, 16, width of the term-count field.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately.
- start  input  1  command strobe; sampled only in IDLE.
- count  input  CW  number of terms to emit; sampled with start.
- seed0  input  W  first term; sampled with start.
- seed1  input  W  second term; sampled with start.
- seed2  input  W  third term; sampled with start.
- abort  input  1  terminates a run in progress.
- out_data  output  W  current term.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the term when high with out_valid.
- term_idx  output  CW  index of the presented term, 0-based.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse on normal completion.
- aborted  output  1  one-cycle pulse when a run is aborted.
- wrapped  output  1  sticky; at least one recurrence sum overflowed W bits this run.

Behaviour:
- Reset (rst=0): state=IDLE. Outputs out_data=0, out_valid=0, term_idx=0, busy=0, done=0, aborted=0, wrapped=0. Internal a=b=c=0, remaining=0.
- All outputs are registered.
- States: IDLE, RUN, DONE.
- IDLE + start=1 + count!=0:
  - Next edge: a<=seed0, b<=seed1, c<=seed2, remaining<=count, term_idx<=0, wrapped<=0, state<=RUN.
  - out_valid=1 and out_data=seed0 in the following cycle (one-cycle latency from start).
- IDLE + start=1 + count==0: next state DONE. No term is emitted. wrapped is cleared.
- RUN:
  - out_data=a and out_valid=1.
  - A transfer occurs when out_valid and out_ready are both 1. On a transfer: a<=b, b<=c, c<=a+b (truncated to W bits), term_idx++, remaining--.
  - If a+b carries out of W bits, wrapped<=1. It holds until the next accepted start.
  - Transfer with remaining==1: state<=DONE and out_valid<=0.
  - out_valid=1 with out_ready=0: out_data, term_idx and all internal registers hold.
- DONE: lasts exactly one cycle with done=1, busy=1, out_valid=0. Then returns to IDLE. done is 0 in every other state.
- abort=1 in RUN:
  - Next edge: state<=IDLE, out_valid<=0, aborted=1 for one cycle, done is never pulsed.
  - Abort takes priority over a simultaneous transfer; that term is considered not accepted.
  - abort in IDLE or DONE is ignored.
- start while busy is ignored; the count and seeds presented with it are not latched.
- start and abort together in IDLE: start wins and abort is ignored.
- A start in the same cycle as DONE is ignored. A new start is accepted from the IDLE cycle onward.
- Reset mid-run: returns to IDLE immediately. No done or aborted pulse.
- Sequence with seeds 0,1,1: 0,1,1,1,2,2,3,4,5,7,9,12,...

Test Plan:
- Basic run: rst released, out_ready=1, start with count=8 and seeds 0,1,1 -> terms 0,1,1,1,2,2,3,4 on 8 consecutive cycles with term_idx 0..7, then done pulses once; busy falls the cycle after done.
- Backpressure: as above with out_ready toggling 1,0,0,1,... -> same 8 values in the same order; out_data and term_idx stable while ready=0; no term duplicated or dropped.
- Zero and busy starts: start with count=0 -> done one cycle later, out_valid never 1. Start with count=5 during a run -> ignored; the run completes its original length.
- Abort: count=10, abort asserted with out_ready=1 while term_idx=3 -> exactly terms 0,1,1 accepted; aborted pulses; done never asserts; next start runs normally.
- Wrap: W=8, seeds 200,100,50, count=4 -> terms 200,100,50,44 (300 mod 256); wrapped=1 after the 200+100 transfer; wrapped=0 after the next start.
- Async reset: rst=0 asserted mid-run between clock edges -> out_valid, busy and wrapped go to 0 without waiting for a clock edge; after rst=1, state is IDLE.

Source files
------------

// File: rtl/seq_run_ctrl.sv
// seq_run_ctrl: command-driven three-term recurrence generator with a
// valid/ready output stream, programmable seeds and length, abort, and
// sticky wrap (carry-out) detection.
module seq_run_ctrl #(
  parameter int unsigned W  = 32,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] count,
  input  logic [W-1:0]  seed0,
  input  logic [W-1:0]  seed1,
  input  logic [W-1:0]  seed2,
  input  logic          abort,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] term_idx,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic          wrapped
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  a, b, c;
  logic [W-1:0]  a_nxt, b_nxt, c_nxt;
  logic [CW-1:0] remaining, remaining_nxt;
  logic [W-1:0]  out_data_nxt;
  logic          out_valid_nxt;
  logic [CW-1:0] term_idx_nxt;
  logic          busy_nxt;
  logic          done_nxt;
  logic          aborted_nxt;
  logic          wrapped_nxt;
  logic [W:0]    sum_c;

  // Recurrence sum with the carry bit kept for wrap detection
  always_comb begin
    sum_c = (W+1)'(a) + (W+1)'(b);
  end

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      term_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      wrapped   <= 1'b0;
    end else begin
      state     <= state_nxt;
      a         <= a_nxt;
      b         <= b_nxt;
      c         <= c_nxt;
      remaining <= remaining_nxt;
      out_data  <= out_data_nxt;
      out_valid <= out_valid_nxt;
      term_idx  <= term_idx_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      aborted   <= aborted_nxt;
      wrapped   <= wrapped_nxt;
    end
  end

  // Next-state and next-output logic; everything holds unless changed below
  always_comb begin
    state_nxt     = state;
    a_nxt         = a;
    b_nxt         = b;
    c_nxt         = c;
    remaining_nxt = remaining;
    out_data_nxt  = out_data;
    out_valid_nxt = out_valid;
    term_idx_nxt  = term_idx;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    aborted_nxt   = 1'b0;
    wrapped_nxt   = wrapped;

    case (state)
      IDLE: begin
        // start beats a simultaneous abort; abort alone is ignored here
        if (start) begin
          wrapped_nxt = 1'b0;
          busy_nxt    = 1'b1;
          if (count != '0) begin
            a_nxt         = seed0;
            b_nxt         = seed1;
            c_nxt         = seed2;
            remaining_nxt = count;
            term_idx_nxt  = '0;
            out_data_nxt  = seed0;
            out_valid_nxt = 1'b1;
            state_nxt     = RUN;
          end else begin
            done_nxt  = 1'b1;
            state_nxt = DONE;
          end
        end
      end

      RUN: begin
        // abort wins over a transfer in the same cycle
        if (abort) begin
          out_valid_nxt = 1'b0;
          busy_nxt      = 1'b0;
          aborted_nxt   = 1'b1;
          state_nxt     = IDLE;
        end else if (out_valid && out_ready) begin
          a_nxt         = b;
          b_nxt         = c;
          c_nxt         = sum_c[W-1:0];
          out_data_nxt  = b;
          term_idx_nxt  = term_idx + CW'(1);
          remaining_nxt = remaining - CW'(1);
          if (sum_c[W]) begin
            wrapped_nxt = 1'b1;
          end
          if (remaining == CW'(1)) begin
            out_valid_nxt = 1'b0;
            done_nxt      = 1'b1;
            state_nxt     = DONE;
          end
        end
      end

      DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end

      default: begin
        out_valid_nxt = 1'b0;
        busy_nxt      = 1'b0;
        state_nxt     = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_run_ctrl.sv
// Scoreboard bench for seq_run_ctrl: a reference model expands each accepted
// start into its full term list; a negedge monitor pops terms as they are
// accepted and checks the per-cycle status flags.
module tb_seq_run_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] count = '0;
  logic [W-1:0]  seed0 = '0;
  logic [W-1:0]  seed1 = '0;
  logic [W-1:0]  seed2 = '0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic [CW-1:0] term_idx;
  logic          busy;
  logic          done;
  logic          aborted;
  logic          wrapped;

  always #5 clk = ~clk;

  seq_run_ctrl #(.W(W), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .count    (count),
    .seed0    (seed0),
    .seed1    (seed1),
    .seed2    (seed2),
    .abort    (abort),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .term_idx (term_idx),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .wrapped  (wrapped)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream items
  typedef struct {
    logic [W-1:0]  data;
    logic [CW-1:0] idx;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: phase 0 = idle, 1 = emitting, 2 = completion cycle
  int           m_phase = 0;
  int           m_left  = 0;
  int           m_k     = 0;
  bit           m_wrap  = 1'b0;
  bit           m_ab    = 1'b0;
  logic [W-1:0] m_t[$];

  always @(posedge clk) begin
    if (!rst) begin
      m_phase = 0;
      m_left  = 0;
      m_k     = 0;
      m_wrap  = 1'b0;
      m_ab    = 1'b0;
      exp_q.delete();
    end else begin
      m_ab = 1'b0;
      case (m_phase)
        0: if (start) begin
          m_wrap = 1'b0;
          if (count == 0) begin
            m_phase = 2;
          end else begin
            m_t.delete();
            m_t.push_back(seed0);
            m_t.push_back(seed1);
            m_t.push_back(seed2);
            for (int k = 3; k <= int'(count) + 1; k++)
              m_t.push_back(W'(m_t[k-3] + m_t[k-2]));
            for (int i = 0; i < int'(count); i++)
              exp_q.push_back('{data: m_t[i], idx: CW'(i)});
            m_left  = int'(count);
            m_k     = 0;
            m_phase = 1;
          end
        end
        1: if (abort) begin
          m_phase = 0;
          m_ab    = 1'b1;
          exp_q.delete();
        end else if (out_ready) begin
          if ((longint'(m_t[m_k]) + longint'(m_t[m_k+1])) >= (longint'(1) << W))
            m_wrap = 1'b1;
          m_k++;
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Monitor: status flags every cycle, stream contents when presented
  always @(negedge clk) begin
    if (rst) begin
      chk("out_valid", 64'(out_valid), 64'(m_phase == 1));
      chk("busy",      64'(busy),      64'(m_phase != 0));
      chk("done",      64'(done),      64'(m_phase == 2));
      chk("aborted",   64'(aborted),   64'(m_ab));
      chk("wrapped",   64'(wrapped),   64'(m_wrap));
      if (out_valid) begin
        chk("term_pending", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          chk("out_data", 64'(out_data), 64'(exp_q[0].data));
          chk("term_idx", 64'(term_idx), 64'(exp_q[0].idx));
          if (out_ready && !abort) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int c, input int s0, input int s1, input int s2);
    start = 1'b1;
    count = CW'(c);
    seed0 = W'(s0);
    seed1 = W'(s1);
    seed2 = W'(s2);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || m_phase != 0) && n < 300) begin
      tick();
      n++;
    end
    chk("idle_reached", 64'(busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_term_idx", 64'(term_idx), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    tick();

    // Basic run
    out_ready = 1'b1;
    do_start(8, 0, 1, 1);
    wait_idle();
    tick();

    // Backpressure 1,0,0,1,0,0,...
    do_start(8, 0, 1, 1);
    for (int i = 0; i < 40 && (busy || m_phase != 0); i++) begin
      out_ready = (i % 3 == 2);
      tick();
    end
    out_ready = 1'b1;
    wait_idle();

    // Zero count, then a start while busy
    do_start(0, 5, 6, 7);
    wait_idle();
    do_start(8, 0, 1, 1);
    tick();
    tick();
    do_start(5, 9, 9, 9);
    wait_idle();

    // Abort while term 3 is presented
    do_start(10, 0, 1, 1);
    for (int i = 0; i < 30; i++) begin
      if (out_valid && term_idx == CW'(3)) break;
      tick();
    end
    chk("abort_at_idx", 64'(term_idx), 64'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_idle();
    do_start(6, 0, 1, 1);
    wait_idle();

    // Wrap: 200+100 overflows 8 bits
    do_start(4, 200, 100, 50);
    wait_idle();
    tick();
    do_start(3, 1, 2, 3);
    wait_idle();

    // Start and abort together in idle
    abort = 1'b1;
    do_start(4, 3, 4, 5);
    abort = 1'b0;
    wait_idle();

    // Asynchronous reset mid-run
    do_start(10, 200, 100, 50);
    tick();
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_busy",      64'(busy),      64'd0);
    chk("async_wrapped",   64'(wrapped),   64'd0);
    tick();
    rst = 1'b1;
    tick();
    do_start(5, 0, 1, 1);
    wait_idle();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      start     = ($urandom_range(0, 5) == 0);
      count     = CW'($urandom_range(0, 12));
      seed0     = W'($urandom);
      seed1     = W'($urandom);
      seed2     = W'($urandom);
      abort     = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    tick();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
